// File: rtl/diaosi_types_pkg.sv
// Shared types for the diaosi fetch path.
// Holds the set-associative icache controller state encoding.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    ICA_IDLE,
    ICA_FILL,
    ICA_FLUSH
  } ica_state_e;

endpackage

// File: rtl/icache_victim_sel.sv
// Per-set victim choice and replacement-state update.
// WAYS=2 keeps an LRU bit, WAYS=4 a FIFO pointer, WAYS=1 has none.
module icache_victim_sel #(
  parameter int WAYS  = 2,
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rp,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             hit,
  input  logic             fill,
  output logic [WAY_W-1:0] victim,
  output logic [WAY_W-1:0] rp_next
);

  // Lowest invalid way wins; otherwise fall back to the pointer.
  always_comb begin
    victim = (WAYS > 1) ? rp : '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    rp_next = rp;
    unique case (1'b1)
      (WAYS == 2) && (hit || fill):
        rp_next = hit_way ^ WAY_W'(1);
      (WAYS == 4) && fill:
        rp_next = rp + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative multi-word-block instruction cache with
// burst fill, whole-cache flush and saturating perf counters.
module icache_assoc
  import diaosi_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic [31:0]      iload,
  input  logic             iwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int WB    = $clog2(BLKWORDS);
  localparam int IB    = $clog2(SETS);
  localparam int WC_W  = (WB > 0) ? WB : 1;
  localparam int TAG_W = 30 - WB - IB;
  localparam int ISH   = 2 + WB;
  localparam int TSH   = 2 + WB + IB;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  ica_state_e state, state_next;

  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [IB-1:0]    req_idx, fill_idx, sel_idx;
  logic [WC_W-1:0]  req_woff, wcnt;
  logic [WAY_W-1:0] fill_way, hit_way, upd_way;
  logic [WAY_W-1:0] victim, rp_next;
  logic [WAYS-1:0]  way_hit;
  logic             any_hit, hit, miss;
  logic             fill_done, flush_pend, flush_any;

  logic [WAYS-1:0]  valid [SETS];
  logic [WAY_W-1:0] rp    [SETS];
  logic [TAG_W-1:0] tags  [SETS][WAYS];
  logic [31:0]      data  [SETS][WAYS][BLKWORDS];

  assign req_woff = WC_W'((imemaddr >> 2) & 32'(BLKWORDS - 1));
  assign req_idx  = IB'(imemaddr >> ISH);
  assign req_tag  = TAG_W'(imemaddr >> TSH);

  always_comb begin
    way_hit = '0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
        way_hit[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  assign any_hit = |way_hit;
  // A flush request in IDLE suppresses both hit and miss.
  assign hit  = (state == ICA_IDLE) && imemREN && !flush && any_hit;
  assign miss = (state == ICA_IDLE) && imemREN && !flush && !any_hit;

  assign ihit     = hit;
  assign imemload = hit ? data[req_idx][hit_way][req_woff] : '0;

  assign fill_done = (state == ICA_FILL) && !iwait &&
                     (wcnt == WC_W'(BLKWORDS - 1));
  assign flush_any = flush_pend | flush;

  assign iREN  = (state == ICA_FILL);
  assign iaddr = iREN ? ((32'(fill_tag) << TSH) |
                         (32'(fill_idx) << ISH) |
                         (32'(wcnt) << 2)) : '0;

  assign sel_idx = (state == ICA_FILL) ? fill_idx : req_idx;
  assign upd_way = (state == ICA_FILL) ? fill_way : hit_way;

  icache_victim_sel #(
    .WAYS (WAYS),
    .WAY_W(WAY_W)
  ) u_victim (
    .valid  (valid[sel_idx]),
    .rp     (rp[sel_idx]),
    .hit_way(upd_way),
    .hit    (hit),
    .fill   (fill_done),
    .victim (victim),
    .rp_next(rp_next)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ICA_IDLE: begin
        if (flush) state_next = ICA_FLUSH;
        else if (miss) state_next = ICA_FILL;
      end
      ICA_FILL: begin
        if (fill_done)
          state_next = flush_any ? ICA_FLUSH : ICA_IDLE;
      end
      ICA_FLUSH: state_next = ICA_IDLE;
      default:   state_next = ICA_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ICA_IDLE;
      flush_pend <= 1'b0;
      wcnt       <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      fill_way   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rp[s]    <= '0;
      end
    end else begin
      state <= state_next;
      if (hit) begin
        rp[req_idx] <= rp_next;
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
      if (miss) begin
        fill_tag <= req_tag;
        fill_idx <= req_idx;
        fill_way <= victim;
        wcnt     <= '0;
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
      if (state == ICA_FILL && flush) flush_pend <= 1'b1;
      if (state == ICA_FILL && !iwait) wcnt <= wcnt + 1'b1;
      // An evicted victim is rewritten, so its valid bit follows the flush.
      if (fill_done) begin
        valid[fill_idx][fill_way] <= !flush_any;
        rp[fill_idx]              <= rp_next;
        wcnt                      <= '0;
      end
      if (state == ICA_FLUSH) begin
        flush_pend <= 1'b0;
        for (int s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          rp[s]    <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && state == ICA_FILL && !iwait)
      data[fill_idx][fill_way][wcnt] <= iload;
    if (!RST && fill_done)
      tags[fill_idx][fill_way] <= fill_tag;
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed scoreboard bench for icache_assoc (8 sets, 2 ways,
// 2-word blocks, 4-bit counters) with a wait-state memory model.
module tb_icache_assoc;

  localparam int SETS     = 8;
  localparam int WAYS     = 2;
  localparam int BLKWORDS = 2;
  localparam int CNT_W    = 4;
  localparam int WAITS    = 2;
  localparam int LAT_MISS = 1 + BLKWORDS * (WAITS + 1);
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             imemREN = 1'b0;
  logic [31:0]      imemaddr = '0;
  logic             ihit;
  logic [31:0]      imemload;
  logic             flush = 1'b0;
  logic             iREN;
  logic [31:0]      iaddr;
  logic [31:0]      iload = '0;
  logic             iwait = 1'b1;
  logic [CNT_W-1:0] hit_count, miss_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  int wc       = 0;

  logic [31:0] data_q[$];
  logic [31:0] addr_q[$];

  icache_assoc #(
    .SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .flush(flush),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: WAITS busy cycles, then one data cycle, per word.
  always @(posedge CLK) begin
    #1;
    if (iREN) begin
      if (wc < WAITS) begin
        iwait = 1'b1;
        wc++;
      end else begin
        iwait = 1'b0;
        iload = mem_word(iaddr);
        wc = 0;
        if (addr_q.size() == 0)
          check("iaddr_unexpected", iaddr, 32'hffff_ffff);
        else
          check("iaddr", iaddr, addr_q.pop_front());
      end
    end else begin
      iwait = 1'b1;
      iload = '0;
      wc = 0;
    end
  end

  task automatic push_block(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'(BLKWORDS * 4 - 1);
    for (int i = 0; i < BLKWORDS; i++)
      addr_q.push_back(base + 32'(4 * i));
    exp_miss = sat(exp_miss + 1);
  endtask

  task automatic fetch(input logic [31:0] a, input bit miss,
                       input string tag);
    int n;
    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = a;
    data_q.push_back(mem_word(a));
    if (miss) push_block(a);
    n = 0;
    @(negedge CLK);
    while (!ihit && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check({tag, "_ihit"}, 32'(ihit), 32'd1);
    check({tag, "_data"}, imemload, data_q.pop_front());
    check({tag, "_lat"}, 32'(n), miss ? 32'(LAT_MISS) : 32'd0);
    exp_hit = sat(exp_hit + 1);
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  task automatic check_cnt(input string tag);
    @(negedge CLK);
    check({tag, "_hits"}, 32'(hit_count), 32'(exp_hit));
    check({tag, "_miss"}, 32'(miss_count), 32'(exp_miss));
    check({tag, "_iaddr_idle"}, iaddr, 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_iren", 32'(iREN), 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_load", imemload, 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    fetch(32'h40, 1'b1, "cold0");
    fetch(32'h44, 1'b0, "cold1");
    check_cnt("cold");

    fetch(32'h240, 1'b1, "lru_fill9");
    fetch(32'h40, 1'b0, "lru_hit1");
    fetch(32'h440, 1'b1, "lru_fill17");
    fetch(32'h40, 1'b0, "lru_keep1");
    fetch(32'h240, 1'b1, "lru_evicted9");
    check_cnt("lru");

    @(posedge CLK); #1;
    flush = 1'b1;
    imemREN = 1'b1;
    imemaddr = 32'h40;
    @(negedge CLK);
    check("flush_req_ihit", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    @(negedge CLK);
    check("flush_st_ihit", 32'(ihit), 32'd0);
    check("flush_st_iren", 32'(iREN), 32'd0);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    fetch(32'h40, 1'b1, "flush_refill");
    check_cnt("flush");

    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = 32'h80;
    push_block(32'h80);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!(iREN && iaddr == 32'h84) && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check("fwf_word2", iaddr, 32'h84);
    @(posedge CLK); #1;
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    n = 0;
    @(negedge CLK);
    while (iREN && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check("fwf_end_iren", 32'(iREN), 32'd0);
    check("fwf_end_ihit", 32'(ihit), 32'd0);
    fetch(32'h80, 1'b1, "fwf_refetch");
    fetch(32'h40, 1'b1, "fwf_flushed");
    check_cnt("fwf");

    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = 32'h108;
    push_block(32'h108);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    imemaddr = 32'h3000;
    n = 0;
    @(negedge CLK);
    while (iREN && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check("drop_fill_cycles", 32'(n), 32'(LAT_MISS - 1));
    fetch(32'h108, 1'b0, "drop_w0");
    fetch(32'h10c, 1'b0, "drop_w1");
    check_cnt("drop");

    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      imemREN = 1'b1;
      imemaddr = 32'h10c;
      @(negedge CLK);
      check("sat_ihit", 32'(ihit), 32'd1);
      check("sat_data", imemload, mem_word(32'h10c));
    end
    exp_hit = sat(exp_hit + 20);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    check_cnt("sat");
    check("sat_hold", 32'(hit_count), 32'(CMAX));

    @(posedge CLK); #1;
    imemREN = 1'b1;
    imemaddr = 32'h200;
    push_block(32'h200);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!(iREN && iaddr == 32'h204) && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check("rstf_word2", iaddr, 32'h204);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rstf_iren", 32'(iREN), 32'd0);
    check("rstf_iaddr", iaddr, 32'd0);
    check("rstf_hits", 32'(hit_count), 32'd0);
    check("rstf_miss", 32'(miss_count), 32'd0);
    addr_q.delete();
    data_q.delete();
    exp_hit = 0;
    exp_miss = 0;
    fetch(32'h200, 1'b1, "rstf_refetch");
    fetch(32'h40, 1'b1, "rstf_cold");
    check_cnt("rstf");
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
